// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one SDRAM controller between video, CPU and command-engine requesters
// and schedules periodic auto-refresh. Define VRAM_ARB_VIDEO32_EN for a 32-bit video read path.
module vram_arbiter #(
    parameter int FREQ           = 54_000_000,
    parameter int REFRESH_CYCLES = FREQ / 1_000_000 * 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vid_req,
    input  logic [22:0] vid_addr,
    output logic        vid_ack,
`ifdef VRAM_ARB_VIDEO32_EN
    output logic [31:0] vid_rdata,
`else
    output logic [15:0] vid_rdata,
`endif
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        cmd_req,
    input  logic        cmd_we,
    input  logic [22:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        cmd_ack,
    output logic [7:0]  cmd_rdata,
    input  logic        mem_enabled,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_refresh,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_din8,
    input  logic [15:0] mem_dout16,
`ifdef VRAM_ARB_VIDEO32_EN
    input  logic [31:0] mem_dout32,
`endif
    output logic        refresh_overrun
);

`ifdef VRAM_ARB_VIDEO32_EN
    localparam int VW = 32;
`else
    localparam int VW = 16;
`endif
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_VID, SRC_CPU, SRC_CMD, SRC_REF} src_t;

    state_t          state, next_state;
    src_t            src, grant_src;
    logic            grant;
    logic            op_we;
    logic            last_was_cmd;
    logic [1:0]      wait_cnt;
    logic [TW-1:0]   refresh_timer;
    logic            refresh_pending;
    logic            timer_wrap;
    logic [7:0]      rd_byte;
    logic [VW-1:0]   vid_word;

`ifdef VRAM_ARB_VIDEO32_EN
    assign vid_word = mem_dout32;
`else
    assign vid_word = mem_dout16;
`endif
    assign rd_byte    = mem_addr[0] ? mem_dout16[15:8] : mem_dout16[7:0];
    assign timer_wrap = mem_enabled && (refresh_timer == TMAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Refresh beats video, video beats the CPU/command pair, which share by round-robin.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_src  = SRC_VID;
        case (state)
            IDLE: begin
                if (mem_enabled) begin
                    if (refresh_pending) begin
                        grant     = 1'b1;
                        grant_src = SRC_REF;
                    end else if (vid_req) begin
                        grant     = 1'b1;
                        grant_src = SRC_VID;
                    end else if (cpu_req && cmd_req) begin
                        grant     = 1'b1;
                        grant_src = last_was_cmd ? SRC_CPU : SRC_CMD;
                    end else if (cpu_req) begin
                        grant     = 1'b1;
                        grant_src = SRC_CPU;
                    end else if (cmd_req) begin
                        grant     = 1'b1;
                        grant_src = SRC_CMD;
                    end
                end
                if (grant) begin
                    next_state = ISSUE;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_cnt == 2'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_refresh  <= 1'b0;
            mem_addr     <= '0;
            mem_din8     <= '0;
            src          <= SRC_VID;
            op_we        <= 1'b0;
            last_was_cmd <= 1'b1;
            wait_cnt     <= 2'd0;
            vid_ack      <= 1'b0;
            cpu_ack      <= 1'b0;
            cmd_ack      <= 1'b0;
            vid_rdata    <= '0;
            cpu_rdata    <= '0;
            cmd_rdata    <= '0;
        end else begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            vid_ack     <= 1'b0;
            cpu_ack     <= 1'b0;
            cmd_ack     <= 1'b0;
            if (grant) begin
                src <= grant_src;
                case (grant_src)
                    SRC_VID: begin
                        mem_read <= 1'b1;
                        mem_addr <= vid_addr;
                        op_we    <= 1'b0;
                    end
                    SRC_CPU: begin
                        mem_read     <= !cpu_we;
                        mem_write    <= cpu_we;
                        mem_addr     <= cpu_addr;
                        mem_din8     <= cpu_wdata;
                        op_we        <= cpu_we;
                        last_was_cmd <= 1'b0;
                    end
                    SRC_CMD: begin
                        mem_read     <= !cmd_we;
                        mem_write    <= cmd_we;
                        mem_addr     <= cmd_addr;
                        mem_din8     <= cmd_wdata;
                        op_we        <= cmd_we;
                        last_was_cmd <= 1'b1;
                    end
                    default: begin
                        mem_refresh <= 1'b1;
                        op_we       <= 1'b0;
                    end
                endcase
            end
            // Four WAIT cycles cover controller acceptance plus its busy window.
            if (state == ISSUE) begin
                wait_cnt <= 2'd3;
            end else if (state == WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == DONE) begin
                case (src)
                    SRC_VID: begin
                        vid_ack   <= 1'b1;
                        vid_rdata <= vid_word;
                    end
                    SRC_CPU: begin
                        cpu_ack <= 1'b1;
                        if (!op_we) cpu_rdata <= rd_byte;
                    end
                    SRC_CMD: begin
                        cmd_ack <= 1'b1;
                        if (!op_we) cmd_rdata <= rd_byte;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A wrap sets pending even if a refresh is issued on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            refresh_timer   <= '0;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
        end else begin
            if (!mem_enabled || timer_wrap) begin
                refresh_timer <= '0;
            end else begin
                refresh_timer <= refresh_timer + 1'b1;
            end
            if (timer_wrap) begin
                refresh_pending <= 1'b1;
                if (refresh_pending) refresh_overrun <= 1'b1;
            end else if (grant && grant_src == SRC_REF) begin
                refresh_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single SDRAM memory controller between three VRAM requesters (video fetch, CPU port, command engine) and schedules periodic auto-refresh. Sits directly in front of the memory controller: it owns that controller's `read`/`write`/`refresh` strobes, address and write data, and paces commands so a new one is never issued while the controller is busy. Each requester sees a simple level-request / single-cycle-acknowledge handshake.

## Interface
Parameters:
- `FREQ`, 54_000_000: clock frequency in Hz, for documentation and derived defaults.
- `REFRESH_CYCLES`, 810: clocks between refresh requests (15 µs at 54 MHz).

Ports:
- `clk` in 1: the single clock for the whole block.
- `resetn` in 1: reset, asynchronous and active-low.
- `vid_req` in 1: video read request (read-only port).
- `vid_addr` in 23: video byte address.
- `vid_ack` out 1: one-cycle pulse; `vid_rdata` is valid during this cycle.
- `vid_rdata` out 16 (32 with `VRAM_ARB_VIDEO32_EN`): video read data.
- `cpu_req`, `cpu_we` in 1 each: CPU request and write select.
- `cpu_addr` in 23, `cpu_wdata` in 8: CPU byte address and write data.
- `cpu_ack` out 1, `cpu_rdata` out 8: CPU acknowledge and read data.
- `cmd_req`, `cmd_we`, `cmd_addr`, `cmd_wdata`, `cmd_ack`, `cmd_rdata`: command-engine port, same widths and meanings as the CPU port.
- `mem_enabled` in 1: the memory controller has finished initialisation.
- `mem_read`, `mem_write`, `mem_refresh` out 1 each: registered single-cycle strobes to the controller.
- `mem_addr` out 23, `mem_din8` out 8: registered address and write byte to the controller.
- `mem_dout16` in 16: controller read word.
- `mem_dout32` in 32: present only with `VRAM_ARB_VIDEO32_EN`.
- `refresh_overrun` out 1: sticky; set when a refresh interval expires while a refresh is still pending.

## Operation
- States: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- Nothing is granted, and the refresh timer is held at 0, while `mem_enabled` is 0.
- Grant priority in `IDLE`: pending refresh, then video, then CPU/command.
  - CPU and command round-robin between themselves; the port granted last loses a tie.
- `IDLE` with a winner:
  - Latch the winner's id, address, write enable and write data.
  - Drive exactly one `mem_*` strobe for one cycle (the `ISSUE` state).
- `WAIT`: a 4-cycle counter counts down; this covers controller acceptance plus its 4-cycle busy window.
- `DONE`:
  - Capture read data and pulse the winner's ack for one cycle.
  - Refresh operations pulse no ack.
  - Return to `IDLE`.
- Read data per port:
  - Video: `mem_dout16` (or `mem_dout32`).
  - CPU/command: `addr[0] ? mem_dout16[15:8] : mem_dout16[7:0]`.
- Writes also ack; the read data outputs hold their previous value on a write ack.
- Refresh timer: counts `0..REFRESH_CYCLES-1` and on wrap sets `refresh_pending`.
  - If `refresh_pending` is already set at the wrap, set `refresh_overrun` as well.
  - `refresh_pending` clears when its refresh is issued.
- A requester must hold `req` and its operands stable until its ack.
  - Dropping `req` early does not abort the operation; the ack still pulses.
  - If `req` is still high in the cycle after the ack, that is a new request.
- Reset mid-operation: all state and outputs clear asynchronously. The in-flight access is lost, and requesters re-present it.

## Timing
- Reset values:
  - All `*_ack`, `mem_read`, `mem_write`, `mem_refresh`, `refresh_overrun` = 0.
  - `mem_addr`, `mem_din8`, all `*_rdata` = 0.
  - State `IDLE`; round-robin favours CPU first.
- Grant at edge G, then:
  - Strobe high during G..G+1; the controller samples it at G+1.
  - Controller data is valid after G+5.
  - Ack and rdata register at G+6 and are visible for one cycle.
  - Next grant is possible at G+7.
- One access every 7 clocks; refresh slots cost 7 clocks.
- Ack latency from `req` rising with the arbiter idle: 7 clocks.
- Requests arriving during a non-`IDLE` state wait; they are evaluated at the next `IDLE` cycle.

## Configuration
- `VRAM_ARB_VIDEO32_EN` defined:
  - `vid_rdata` is 32 bits, captured from `mem_dout32`.
  - `mem_dout32` port exists; `vid_addr[1:0]` is forwarded unchanged.
- `VRAM_ARB_VIDEO32_EN` undefined:
  - `vid_rdata` is 16 bits from `mem_dout16`.
  - No `mem_dout32` port.

## Test plan
- Reset, `mem_enabled` = 0, all reqs high for 50 clocks -> no strobes, no acks. Raise `mem_enabled` -> first strobe is `mem_read` for the video port; `vid_ack` follows 6 clocks after the grant.
- CPU write of 0x5A to address 0x000101 -> `mem_write` pulse with `mem_addr` = 0x000101 and `mem_din8` = 0x5A; `cpu_ack` 7 clocks after `req`.
- CPU read of 0x000101 with `mem_dout16` = 0x5A33 -> `cpu_rdata` = 0x5A.
- CPU and command requests held continuously -> acks alternate CPU, command, CPU, …, one every 7 clocks.
- Refresh timer expires while video is requesting -> `mem_refresh` issues before the video read; no ack pulses for the refresh.
- Hold the arbiter off `IDLE` across two refresh wraps -> `refresh_overrun` = 1 and stays 1 until reset. Assert `resetn` low mid-`WAIT` -> all outputs 0 immediately.
